// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller for NDIG common-anode digits.
// Double-buffered update port; new values are committed only at a frame boundary.
module seg_scan_ctrl #(
    parameter int unsigned NDIG      = 4,
    parameter int unsigned DWELL     = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              upd_valid,
    input  logic [4*NDIG-1:0] upd_data,
    output logic              upd_ready,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_done
);

    localparam int unsigned MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int unsigned TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned DW   = 4 * NDIG;

    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
    localparam logic [6:0]    SEG_OFF    = 7'b1111111;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   disp_q, disp_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic            pend_q, pend_d;
    logic            frame_end;
    logic [NDIG-1:0] an_d;
    logic [6:0]      seg_d;
    logic            fd_d;

    // Hex to active-low {g,f,e,d,c,b,a}
    function automatic logic [6:0] dec(input logic [3:0] h);
        case (h)
            4'h0: dec = 7'b1000000;
            4'h1: dec = 7'b1111001;
            4'h2: dec = 7'b0100100;
            4'h3: dec = 7'b0110000;
            4'h4: dec = 7'b0011001;
            4'h5: dec = 7'b0010010;
            4'h6: dec = 7'b0000010;
            4'h7: dec = 7'b1111000;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0010000;
            4'hA: dec = 7'b0001000;
            4'hB: dec = 7'b0000011;
            4'hC: dec = 7'b1000110;
            4'hD: dec = 7'b0100001;
            4'hE: dec = 7'b0000110;
            default: dec = 7'b0001110;
        endcase
    endfunction

    // Next-state, buffer handshake and registered-output values
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        idx_d     = idx_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        frame_end = 1'b0;
        an_d      = '1;
        seg_d     = SEG_OFF;
        fd_d      = 1'b0;

        if (!en) begin
            state_d = ST_BLANK;
            timer_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (timer_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        timer_d = '0;
                    end
                end
                ST_DRIVE: begin
                    if (timer_q == DWELL_LAST) begin
                        state_d = ST_BLANK;
                        timer_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d     = '0;
                            frame_end = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end

        // Commit happens only while pending, so it can never coincide with an accept
        if (upd_valid && !pend_q) begin
            shadow_d = upd_data;
            pend_d   = 1'b1;
        end else if (pend_q && (frame_end || !en)) begin
            disp_d = shadow_q;
            pend_d = 1'b0;
        end

        if (state_d == ST_DRIVE) begin
            an_d  = ~(NDIG'(1) << idx_d);
            seg_d = dec(4'(disp_d >> {idx_d, 2'b00}));
            fd_d  = (idx_d == IDX_LAST) && (timer_d == DWELL_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BLANK;
            timer_q    <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            shadow_q   <= '0;
            pend_q     <= 1'b0;
            an         <= '1;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
            upd_ready  <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            an         <= an_d;
            seg        <= seg_d;
            frame_done <= fd_d;
            upd_ready  <= ~pend_d;
        end
    end

endmodule
